// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch core.
// clog2() is clamped to at least 1 bit, so TICK_DIV=1 still gets a legal prescaler register.
package stopwatch_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_t;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch chain: steps up or down on i_step_en and wraps inside 0..9.
// Carry/borrow flag that this digit sits at its terminal value for the current direction.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_step_en,
  input  logic i_down,
  output bcd_t o_value,
  output logic o_carry_out,
  output logic o_borrow_out
);

  bcd_t r_value;
  bcd_t w_next;

  always_comb begin
    w_next = r_value;
    if (!i_step_en) begin
      w_next = r_value;
    end else if (i_down) begin
      if ((r_value == BCD_MIN) || (r_value > BCD_MAX)) begin
        w_next = BCD_MAX;
      end else begin
        w_next = r_value - 4'd1;
      end
    end else begin
      if (r_value >= BCD_MAX) begin
        w_next = BCD_MIN;
      end else begin
        w_next = r_value + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_value <= BCD_MIN;
    end else if (i_clear) begin
      r_value <= BCD_MIN;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value      = r_value;
  assign o_carry_out  = ~i_down & (r_value == BCD_MAX);
  assign o_borrow_out = i_down & (r_value == BCD_MIN);

endmodule

// File: rtl/bcd_stopwatch.sv
// Parametrised BCD stopwatch: synchronised start/stop and lap buttons, prescaled up/down
// counting with wrap-or-saturate, sticky overflow and a lap freeze of the displayed value.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000,
  parameter int WRAP       = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start_stop,
  input  logic                    i_clear,
  input  logic                    i_lap,
  input  logic                    i_down,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic                    o_running,
  output logic                    o_overflow,
  output logic                    o_lap_active
);

  localparam int             PW         = clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic           SATURATE   = (WRAP == 0) ? 1'b1 : 1'b0;
  localparam int             BTN_SS     = 0;
  localparam int             BTN_LAP    = 1;

  logic [1:0]              w_btn;
  logic [1:0]              r_sync1;
  logic [1:0]              r_sync2;
  logic [1:0]              r_prev;
  logic [1:0]              w_pulse;

  logic [PW-1:0]           r_presc;
  logic                    r_running;
  logic                    r_overflow;
  logic                    r_lap_active;
  logic [4*NUM_DIGITS-1:0] r_lap;

  logic [4*NUM_DIGITS-1:0] w_count;
  logic [NUM_DIGITS-1:0]   w_carry;
  logic [NUM_DIGITS-1:0]   w_borrow;
  logic [NUM_DIGITS-1:0]   w_term;
  logic [NUM_DIGITS-1:0]   w_en;
  logic                    w_step;
  logic                    w_all_term;
  logic                    w_term_event;
  logic                    w_saturate;
  logic                    w_step_adv;

  assign w_btn   = {i_lap, i_start_stop};
  assign w_pulse = r_sync2 & ~r_prev;

  // Two-flop synchroniser plus edge-detect register for both raw buttons.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev  <= 2'b00;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // The step is qualified by the registered running flag, so a same-cycle toggle cannot cancel it.
  assign w_step       = r_running & (r_presc == PRESC_LAST);
  assign w_term       = w_carry | w_borrow;
  assign w_all_term   = &w_term;
  assign w_term_event = w_step & w_all_term;
  assign w_saturate   = w_term_event & SATURATE;
  assign w_step_adv   = w_step & ~w_saturate;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
    end else if (i_clear) begin
      r_presc <= '0;
    end else if (r_running) begin
      if (w_step) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end else begin
      r_presc <= r_presc;
    end
  end

  always_comb begin
    logic v_low;
    w_en = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      v_low = 1'b1;
      for (int j = 0; j < k; j++) begin
        v_low = v_low & w_term[j];
      end
      w_en[k] = w_step_adv & v_low;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (i_clear),
      .i_step_en    (w_en[k]),
      .i_down       (i_down),
      .o_value      (w_count[4*k +: 4]),
      .o_carry_out  (w_carry[k]),
      .o_borrow_out (w_borrow[k])
    );
  end

  // Clear outranks every same-cycle event but deliberately leaves running untouched.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_running    <= 1'b0;
      r_overflow   <= 1'b0;
      r_lap_active <= 1'b0;
      r_lap        <= '0;
    end else if (i_clear) begin
      r_running    <= r_running;
      r_overflow   <= 1'b0;
      r_lap_active <= 1'b0;
      r_lap        <= '0;
    end else begin
      if (w_pulse[BTN_SS]) begin
        r_running <= ~r_running;
      end else if (w_saturate) begin
        r_running <= 1'b0;
      end else begin
        r_running <= r_running;
      end

      if (w_term_event) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end

      if (w_pulse[BTN_LAP] && !r_lap_active) begin
        r_lap        <= w_count;
        r_lap_active <= 1'b1;
      end else if (w_pulse[BTN_LAP]) begin
        r_lap        <= r_lap;
        r_lap_active <= 1'b0;
      end else begin
        r_lap        <= r_lap;
        r_lap_active <= r_lap_active;
      end
    end
  end

  assign o_digits     = r_lap_active ? r_lap : w_count;
  assign o_running    = r_running;
  assign o_overflow   = r_overflow;
  assign o_lap_active = r_lap_active;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomised bench for bcd_stopwatch: three configurations share the same button stimulus and
// are compared every cycle against an integer-valued reference model of the stopwatch rules.
module tb_bcd_stopwatch;

  localparam int ND [0:2] = '{4, 2, 2};
  localparam int TD [0:2] = '{1, 1, 5};
  localparam int WR [0:2] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic        down;
  logic [15:0] a_digits;
  logic [7:0]  b_digits;
  logic [7:0]  c_digits;
  logic [2:0]  running;
  logic [2:0]  overflow;
  logic [2:0]  lap_active;

  int vectors = 0;
  int miscompares = 0;

  int       m_count  [0:2];
  int       m_presc  [0:2];
  int       m_lap    [0:2];
  bit       m_run    [0:2];
  bit       m_ovf    [0:2];
  bit       m_lapact [0:2];
  bit [2:0] ss_hist;
  bit [2:0] lap_hist;

  always #5 clk = ~clk;

  bcd_stopwatch #(.NUM_DIGITS(4), .TICK_DIV(1), .WRAP(1)) u_a (
    .i_clk(clk), .i_reset(reset), .i_start_stop(start_stop), .i_clear(clear), .i_lap(lap),
    .i_down(down), .o_digits(a_digits), .o_running(running[0]), .o_overflow(overflow[0]),
    .o_lap_active(lap_active[0]));

  bcd_stopwatch #(.NUM_DIGITS(2), .TICK_DIV(1), .WRAP(0)) u_b (
    .i_clk(clk), .i_reset(reset), .i_start_stop(start_stop), .i_clear(clear), .i_lap(lap),
    .i_down(down), .o_digits(b_digits), .o_running(running[1]), .o_overflow(overflow[1]),
    .o_lap_active(lap_active[1]));

  bcd_stopwatch #(.NUM_DIGITS(2), .TICK_DIV(5), .WRAP(1)) u_c (
    .i_clk(clk), .i_reset(reset), .i_start_stop(start_stop), .i_clear(clear), .i_lap(lap),
    .i_down(down), .o_digits(c_digits), .o_running(running[2]), .o_overflow(overflow[2]),
    .o_lap_active(lap_active[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int value, input int n);
    logic [31:0] r;
    int v;
    r = 32'd0;
    v = value;
    for (int k = 0; k < n; k++) begin
      r = r | (32'(v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_count[i] = 0; m_presc[i] = 0; m_lap[i] = 0;
      m_run[i] = 1'b0; m_ovf[i] = 1'b0; m_lapact[i] = 1'b0;
    end
    ss_hist  = 3'b000;
    lap_hist = 3'b000;
  endtask

  // Applies one rising clock edge to the model, using the inputs held stable across that edge.
  task automatic model_step();
    bit ss_edge, lap_edge, step, sat;
    int old, top;
    if (reset) begin
      model_reset();
      return;
    end
    ss_edge  = ss_hist[1] & ~ss_hist[2];
    lap_edge = lap_hist[1] & ~lap_hist[2];
    for (int i = 0; i < 3; i++) begin
      step = m_run[i] && (m_presc[i] == TD[i] - 1);
      old  = m_count[i];
      top  = pow10(ND[i]) - 1;
      sat  = 1'b0;
      if (clear) begin
        m_count[i] = 0; m_presc[i] = 0; m_ovf[i] = 1'b0; m_lapact[i] = 1'b0; m_lap[i] = 0;
      end else begin
        if (m_run[i]) m_presc[i] = step ? 0 : m_presc[i] + 1;
        if (step && down) begin
          if (old == 0) begin
            m_ovf[i] = 1'b1;
            if (WR[i] != 0) m_count[i] = top; else sat = 1'b1;
          end else m_count[i] = old - 1;
        end else if (step) begin
          if (old == top) begin
            m_ovf[i] = 1'b1;
            if (WR[i] != 0) m_count[i] = 0; else sat = 1'b1;
          end else m_count[i] = old + 1;
        end
        if (ss_edge) m_run[i] = !m_run[i];
        else if (sat) m_run[i] = 1'b0;
        if (lap_edge && !m_lapact[i]) begin
          m_lap[i] = old;
          m_lapact[i] = 1'b1;
        end else if (lap_edge) m_lapact[i] = 1'b0;
      end
    end
    ss_hist  = {ss_hist[1:0], start_stop};
    lap_hist = {lap_hist[1:0], lap};
  endtask

  task automatic check_all();
    logic [31:0] got_d, exp_d;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: got_d = {16'd0, a_digits};
        1: got_d = {24'd0, b_digits};
        default: got_d = {24'd0, c_digits};
      endcase
      exp_d = m_lapact[i] ? to_bcd(m_lap[i], ND[i]) : to_bcd(m_count[i], ND[i]);
      check_val($sformatf("u%0d.digits", i), got_d, exp_d);
      check_val($sformatf("u%0d.running", i), {31'd0, running[i]}, {31'd0, m_run[i]});
      check_val($sformatf("u%0d.overflow", i), {31'd0, overflow[i]}, {31'd0, m_ovf[i]});
      check_val($sformatf("u%0d.lap_active", i), {31'd0, lap_active[i]}, {31'd0, m_lapact[i]});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int len;
    reset = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; down = 1'b0;
    model_reset();
    repeat (3) cyc();
    reset = 1'b0;

    // Start, count a little, then pull reset between clock edges.
    start_stop = 1'b1;
    repeat (4) cyc();
    start_stop = 1'b0;
    repeat (14) cyc();
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    repeat (2) cyc();
    reset = 1'b0;

    // Long up-run so the 4-digit instance wraps 9999 -> 0000, then clear while running.
    start_stop = 1'b1;
    repeat (3) cyc();
    start_stop = 1'b0;
    repeat (10010) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (5) cyc();

    // A held button gives a single toggle.
    start_stop = 1'b1;
    repeat (20) cyc();
    start_stop = 1'b0;
    repeat (5) cyc();

    for (int seg = 0; seg < 50; seg++) begin
      down = ($urandom_range(0, 1) == 0);
      len  = $urandom_range(20, 300);
      for (int n = 0; n < len; n++) begin
        if ($urandom_range(0, 39) == 0) start_stop = ~start_stop;
        if ($urandom_range(0, 15) == 0) lap = ~lap;
        clear = ($urandom_range(0, 79) == 0);
        cyc();
      end
      clear = 1'b0;
    end

    // Lap edge, clear and a possible step landing in the same cycle.
    lap = 1'b0; start_stop = 1'b0; down = 1'b0;
    repeat (4) cyc();
    lap = 1'b1;
    repeat (2) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
